// File: rtl/snoop_bus_arbiter_pkg.sv
// Shared types for the snooping-bus arbiter.
// Bus operations and arbiter FSM states.
package snoop_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      NOOP       = 2'd0,
      READ_MISS  = 2'd1,
      WRITE_MISS = 2'd2,
      INVALIDATE = 2'd3
   } bus_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      ACK  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/snoop_bus_arbiter_rr_pick.sv
// Rotating-priority encoder.
// First eligible index at or after rr_ptr, wrapping.
module snoop_bus_arbiter_rr_pick #(
   parameter int NUM_CORES = 4,
   localparam int OWN_W = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] eligible,
   input  logic [OWN_W-1:0]     rr_ptr,
   output logic                 found,
   output logic [OWN_W-1:0]     winner
);

   localparam logic [OWN_W:0] N_W = (OWN_W + 1)'(NUM_CORES);

   logic [OWN_W:0] sum;

   // Scan farthest offset first so the nearest eligible core wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (OWN_W + 1)'(k);
         if (sum >= N_W) begin
            sum = sum - N_W;
         end
         if (eligible[sum[OWN_W-1:0]]) begin
            found  = 1'b1;
            winner = sum[OWN_W-1:0];
         end
      end
   end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus master for NUM_CORES caches.
// Round-robin grant, one transaction at a time.
module snoop_bus_arbiter
   import snoop_bus_arbiter_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int TIMEOUT   = 255,
   localparam int OWN_W    = $clog2(NUM_CORES)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_CORES-1:0]             req,
   input  bus_op_t [NUM_CORES-1:0]          req_op,
   input  logic [NUM_CORES-1:0][ADDR_W-1:0] req_addr,
   input  logic                             bus_done,
   output logic                             bus_valid,
   output bus_op_t                          bus_op,
   output logic [ADDR_W-1:0]                bus_addr,
   output logic [OWN_W-1:0]                 bus_owner,
   output logic [NUM_CORES-1:0]             ack,
   output logic                             timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_t           state;
   logic [NUM_CORES-1:0] eligible;
   logic [OWN_W-1:0]     rr_ptr;
   logic [OWN_W-1:0]     winner;
   logic                 found;
   logic [CNT_W-1:0]     wait_cnt;

   // NOOP requests are never candidates for the bus.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         eligible[i] = req[i] && (req_op[i] != NOOP);
      end
   end

   snoop_bus_arbiter_rr_pick #(
      .NUM_CORES(NUM_CORES)
   ) u_pick (
      .eligible(eligible),
      .rr_ptr  (rr_ptr),
      .found   (found),
      .winner  (winner)
   );

   // Grant, hold until done or timeout, then one ack cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus_valid   <= 1'b0;
         bus_op      <= NOOP;
         bus_addr    <= '0;
         bus_owner   <= '0;
         ack         <= '0;
         rr_ptr      <= '0;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         ack <= '0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  bus_op    <= req_op[winner];
                  bus_addr  <= req_addr[winner];
                  bus_owner <= winner;
                  bus_valid <= 1'b1;
                  wait_cnt  <= '0;
                  rr_ptr    <= (winner == OWN_W'(NUM_CORES - 1)) ?
                               '0 : winner + 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (bus_done || (wait_cnt == CNT_LAST)) begin
                  ack       <= NUM_CORES'(1) << bus_owner;
                  bus_valid <= 1'b0;
                  if (!bus_done) begin
                     timeout_err <= 1'b1;
                  end
                  state <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
